controller_nios_cpu_debug_cmd_bridge: RTL and testbench

- Parametrised successor to the Nios II debug-slave sysclk stage.
- Turns virtual-JTAG update strobes (vs_udr, vs_uir), arriving asynchronously from the TCK domain, into buffered, flow-controlled debug commands in the clk domain.
- Replaces fixed take_action_* pulses with a valid/ready command stream, and adds a FIFO, overflow reporting and generic IR/DR widths.
- Sits between the debug-slave TCK stage and the OCI break/ocimem/trace controllers.

---
 rtl/controller_nios_cpu_debug_pkg.sv | 20 ++
 rtl/controller_nios_cpu_debug_sync_edge.sv | 33 +++
 rtl/controller_nios_cpu_debug_cmd_bridge.sv | 106 ++++++++++
 tb/tb_controller_nios_cpu_debug_cmd_bridge.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/controller_nios_cpu_debug_pkg.sv
// controller_nios_cpu_debug_pkg: shared command entry type, IR codes and clog2 helper for the debug command bridge
package controller_nios_cpu_debug_pkg;
  localparam int IR_OCIMEM    = 0;
  localparam int IR_TRACE     = 1;
  localparam int IR_BREAK     = 2;
  localparam int IR_TRACECTRL = 3;
  localparam int DEF_IR_W     = 2;
  localparam int DEF_SR_W     = 38;
  typedef struct packed {
    logic                is_ir;
    logic [DEF_IR_W-1:0] ir;
    logic [DEF_SR_W-1:0] data;
  } cmd_entry_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/controller_nios_cpu_debug_sync_edge.sv
// controller_nios_cpu_debug_sync_edge: strobe_i synchroniser + warm-up gate, pulse_o one-cycle rising-edge pulse (clk, reset_n async low)
module controller_nios_cpu_debug_sync_edge
  import controller_nios_cpu_debug_pkg::*;
#(
  parameter int SYNC_STAGES = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic strobe_i,
  output logic pulse_o
);
  localparam int CW = clog2(SYNC_STAGES + 2);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [CW-1:0]          warm_q, warm_d;
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], strobe_i};
    prev_d  = sync_q[SYNC_STAGES-1];
    warm_d  = (warm_q == '0) ? warm_q : warm_q - CW'(1);
    pulse_o = sync_q[SYNC_STAGES-1] & ~prev_q & (warm_q == '0);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      warm_q <= CW'(SYNC_STAGES + 1);
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      warm_q <= warm_d;
    end
  end
endmodule

// File: rtl/controller_nios_cpu_debug_cmd_bridge.sv
// controller_nios_cpu_debug_cmd_bridge: vs_udr/vs_uir strobes -> FIFO'd cmd_valid/cmd_ready stream {cmd_is_ir,cmd_ir,cmd_data,cmd_ts}, fifo_level, sticky ovf/ovf_clr; CONTROLLER_DEBUG_CMD_TIMESTAMP_EN adds cmd_ts
module controller_nios_cpu_debug_cmd_bridge
  import controller_nios_cpu_debug_pkg::*;
#(
  parameter int IR_W        = 2,
  parameter int SR_W        = 38,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 3,
  parameter int NOACT_BIT   = 35
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [IR_W-1:0]       ir_in,
  input  logic [SR_W-1:0]       sr,
  input  logic                  vs_udr,
  input  logic                  vs_uir,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic                  cmd_is_ir,
  output logic [IR_W-1:0]       cmd_ir,
  output logic [SR_W-1:0]       cmd_data,
  output logic                  cmd_no_action,
  output logic [31:0]           cmd_ts,
  output logic [clog2(DEPTH):0] fifo_level,
  output logic                  ovf,
  input  logic                  ovf_clr
);
  localparam int AW = clog2(DEPTH);
  localparam int EW = 1 + IR_W + SR_W;
  logic          dr_edge, ir_edge;
  logic          push, pop, full, accept;
  logic [EW-1:0] push_entry, head;
  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] pend_q, pend_d;
  logic          pend_v_q, pend_v_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   level_q, level_d;
  logic          ovf_q, ovf_d;
  controller_nios_cpu_debug_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dr (
    .clk      (clk),
    .reset_n  (reset_n),
    .strobe_i (vs_udr),
    .pulse_o  (dr_edge)
  );
  controller_nios_cpu_debug_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ir (
    .clk      (clk),
    .reset_n  (reset_n),
    .strobe_i (vs_uir),
    .pulse_o  (ir_edge)
  );
  // A deferred IR can never coincide with a fresh edge: both strobes edged one cycle earlier.
  always_comb begin
    push       = dr_edge | ir_edge | pend_v_q;
    push_entry = dr_edge ? {1'b0, ir_in, sr} : ir_edge ? {1'b1, ir_in, sr} : pend_q;
    pend_v_d   = dr_edge & ir_edge;
    pend_d     = {1'b1, ir_in, sr};
    full       = level_q == (AW+1)'(DEPTH);
    pop        = cmd_valid & cmd_ready;
    accept     = push & (~full | pop);
    wr_d       = wr_q + AW'(accept);
    rd_d       = rd_q + AW'(pop);
    level_d    = level_q + (AW+1)'(accept) - (AW+1)'(pop);
    ovf_d      = (push & full & ~pop) | (ovf_q & ~ovf_clr);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      wr_q     <= '0;
      rd_q     <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_q] <= push_entry;
  end
  // Head is gated by valid so the unreset storage never reaches the outputs.
  assign cmd_valid     = level_q != '0;
  assign head          = cmd_valid ? mem_q[rd_q] : '0;
  assign {cmd_is_ir, cmd_ir, cmd_data} = head;
  assign cmd_no_action = cmd_data[NOACT_BIT];
  assign fifo_level    = level_q;
  assign ovf           = ovf_q;
`ifdef CONTROLLER_DEBUG_CMD_TIMESTAMP_EN
  logic [31:0] ts_q;
  logic [31:0] ts_mem_q [DEPTH];
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ts_q <= '0;
    else ts_q <= ts_q + 32'd1;
  end
  always_ff @(posedge clk) begin
    if (accept) ts_mem_q[wr_q] <= ts_q;
  end
  assign cmd_ts = cmd_valid ? ts_mem_q[rd_q] : '0;
`else
  assign cmd_ts = '0;
`endif
endmodule

// File: tb/tb_controller_nios_cpu_debug_cmd_bridge.sv
// tb_controller_nios_cpu_debug_cmd_bridge: directed self-checking bench for the debug command bridge
module tb_controller_nios_cpu_debug_cmd_bridge;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  ir_in = '0;
  logic [37:0] sr = '0;
  logic        vs_udr = 1'b0;
  logic        vs_uir = 1'b0;
  logic        cmd_valid, cmd_ready = 1'b0;
  logic        cmd_is_ir, cmd_no_action, ovf, ovf_clr = 1'b0;
  logic [1:0]  cmd_ir;
  logic [37:0] cmd_data;
  logic [31:0] cmd_ts;
  logic [2:0]  fifo_level;
  int          total = 0;
  int          bad = 0;
  logic        seen;
  always #5 clk = ~clk;
  controller_nios_cpu_debug_cmd_bridge #(
    .IR_W(2), .SR_W(38), .DEPTH(4), .SYNC_STAGES(3), .NOACT_BIT(35)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .ir_in         (ir_in),
    .sr            (sr),
    .vs_udr        (vs_udr),
    .vs_uir        (vs_uir),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_is_ir     (cmd_is_ir),
    .cmd_ir        (cmd_ir),
    .cmd_data      (cmd_data),
    .cmd_no_action (cmd_no_action),
    .cmd_ts        (cmd_ts),
    .fifo_level    (fifo_level),
    .ovf           (ovf),
    .ovf_clr       (ovf_clr)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic pulse(input logic dr, input logic ir, input logic [1:0] irv, input logic [37:0] srv);
    ir_in  = irv;
    sr     = srv;
    vs_udr = dr;
    vs_uir = ir;
    step(2);
    vs_udr = 1'b0;
    vs_uir = 1'b0;
    step(6);
  endtask
  task automatic pop_check(input string tag, input logic is_ir, input logic [1:0] irv, input logic [37:0] srv);
    check({tag, "_valid"}, 64'(cmd_valid), 64'd1);
    check({tag, "_head"}, {23'd0, cmd_is_ir, cmd_ir, cmd_data}, {23'd0, is_ir, irv, srv});
    cmd_ready = 1'b1;
    step(1);
    cmd_ready = 1'b0;
  endtask
  task automatic watch_idle(input int n);
    seen = 1'b0;
    repeat (n) begin
      step(1);
      seen = seen | cmd_valid | (fifo_level != 0);
    end
  endtask
  initial begin
    vs_udr = 1'b1;
    step(2);
    check("rst_valid", 64'(cmd_valid), 64'd0);
    check("rst_level", 64'(fifo_level), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_data", {25'd0, cmd_is_ir, cmd_ir, cmd_no_action, cmd_data}, 64'd0);
    check("rst_ts", 64'(cmd_ts), 64'd0);
    reset_n = 1'b1;
    watch_idle(20);
    check("warm_no_cmd", 64'(seen), 64'd0);
    vs_udr = 1'b0;
    step(6);
    ir_in  = 2'b10;
    sr     = 38'h2A_DEAD_BEEF;
    vs_udr = 1'b1;
    step(3);
    check("lat_early", 64'(cmd_valid), 64'd0);
    step(1);
    check("lat_valid", 64'(cmd_valid), 64'd1);
    check("dr_is_ir", 64'(cmd_is_ir), 64'd0);
    check("dr_ir", 64'(cmd_ir), 64'd2);
    check("dr_data", 64'(cmd_data), 64'h2A_DEAD_BEEF);
    check("dr_noact", 64'(cmd_no_action), 64'd1);
    cmd_ready = 1'b1;
    vs_udr = 1'b0;
    step(1);
    cmd_ready = 1'b0;
    check("dr_popped", 64'(cmd_valid), 64'd0);
    step(6);
    ir_in  = 2'b01;
    sr     = 38'h01_2345_6789;
    vs_udr = 1'b1;
    vs_uir = 1'b1;
    step(4);
    check("sim_lvl1", 64'(fifo_level), 64'd1);
    step(1);
    check("sim_lvl2", 64'(fifo_level), 64'd2);
    vs_udr = 1'b0;
    vs_uir = 1'b0;
    step(4);
    check("sim_hold", 64'(fifo_level), 64'd2);
    pop_check("sim_dr", 1'b0, 2'b01, 38'h01_2345_6789);
    pop_check("sim_ir", 1'b1, 2'b01, 38'h01_2345_6789);
    check("sim_empty", 64'(cmd_valid), 64'd0);
    for (int i = 1; i <= 6; i++) pulse(1'b1, 1'b0, 2'b11, 38'(i));
    check("ovf_level", 64'(fifo_level), 64'd4);
    check("ovf_set", 64'(ovf), 64'd1);
    check("ovf_noact", 64'(cmd_no_action), 64'd0);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    check("ovf_clr", 64'(ovf), 64'd0);
    for (int i = 1; i <= 4; i++) pop_check($sformatf("ovf_pop%0d", i), 1'b0, 2'b11, 38'(i));
    check("ovf_empty", 64'(cmd_valid), 64'd0);
    for (int i = 0; i < 4; i++) pulse(1'b1, 1'b0, 2'b00, 38'h10 + 38'(i));
    check("full_level", 64'(fifo_level), 64'd4);
    sr     = 38'h14;
    vs_udr = 1'b1;
    step(3);
    cmd_ready = 1'b1;
    step(1);
    cmd_ready = 1'b0;
    vs_udr    = 1'b0;
    check("pp_level", 64'(fifo_level), 64'd4);
    check("pp_ovf", 64'(ovf), 64'd0);
    step(6);
    for (int i = 1; i <= 4; i++) pop_check($sformatf("pp_pop%0d", i), 1'b0, 2'b00, 38'h10 + 38'(i));
    for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0, 2'b01, 38'h20 + 38'(i));
    check("mid_level", 64'(fifo_level), 64'd3);
    vs_udr = 1'b1;
    vs_uir = 1'b1;
    step(2);
    #2 reset_n = 1'b0;
    #1;
    check("mid_valid", 64'(cmd_valid), 64'd0);
    check("mid_lvl0", 64'(fifo_level), 64'd0);
    check("mid_data", {25'd0, cmd_is_ir, cmd_ir, cmd_no_action, cmd_data}, 64'd0);
    vs_udr = 1'b0;
    vs_uir = 1'b0;
    step(2);
    reset_n = 1'b1;
    watch_idle(20);
    check("mid_stale", 64'(seen), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
